ext_result_fifo: RTL and testbench
==================================

# ext_result_fifo

Capture buffer that sits directly downstream of the external pipelined logic stage. It accepts each 32-bit result qualified by its one-cycle enable strobe and holds the results in order in a FIFO. The IDS slave drains the FIFO with read pops, which removes the requirement to read each result within one cycle of its enable. Occupancy and sticky overflow/underflow status are exposed for software-visible registers.

## Interface
- bus_width, 32, data width of stored results
- depth, 8, FIFO entries; power of two, minimum 2
- cnt_width, $clog2(depth)+1, width of occupancy count (derived; do not override)

- clk  input  1  clock shared with the master and the external logic stage
- rst  input  1  reset; one clock, synchronous, active-high
- result_r  input  bus_width  result word from the upstream pipeline stage
- result_r_in_enb  input  1  one-cycle qualifier for result_r; push request
- rd_en  input  1  pop request from the IDS slave register read
- clr_err  input  1  clears the sticky overflow/underflow flags
- rd_data  output  bus_width  popped word, registered
- rd_valid  output  1  rd_data updated this cycle with a valid word
- count  output  cnt_width  current occupancy, 0..depth
- empty  output  1  count == 0
- full  output  1  count == depth
- overflow  output  1  sticky: a push was dropped
- underflow  output  1  sticky: a pop hit an empty FIFO

## Operation
- Storage: depth x bus_width array. Write pointer and read pointer are each log2(depth) bits and wrap modulo depth. The occupancy register is cnt_width bits.
- Push is accepted when result_r_in_enb=1 and (full=0 or a pop is accepted in the same cycle).
  - On acceptance, result_r is written at wr_ptr and wr_ptr increments.
- Pop is accepted when rd_en=1 and empty=0.
  - rd_data is loaded from mem[rd_ptr] and rd_ptr increments.
  - rd_valid=1 in the following cycle.
- count update per cycle:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Simultaneous push and pop when full: both are accepted, count stays at depth, and there is no overflow.
- Simultaneous push and pop when empty: there is no fall-through. The pop is rejected and underflow is set. The push is accepted and count becomes 1.
- Push when full with no accepted pop: the word is dropped, overflow is set, and pointers and count are unchanged.
- Pop when empty: rd_data holds its previous value, rd_valid=0, and underflow is set.
- Sticky flags:
  - clr_err=1 clears overflow and underflow.
  - If a new error event occurs in the same cycle as clr_err, the event wins and the flag is 1 next cycle.
- Memory contents are not reset. Only pointers, count, flags and outputs are reset.

## Timing
- Reset: while rst=1 at a clock edge, the next state is count=0, empty=1, full=0, overflow=0, underflow=0, rd_data=0, rd_valid=0, and both pointers 0.
- Reset mid-operation discards all stored entries. The first push after rst deasserts is stored at entry 0.
- count, empty and full reflect all pushes and pops through the previous edge.
  - empty and full are decoded from the registered count and carry no combinational path from the inputs.
- Read latency: rd_en sampled at edge N gives rd_data/rd_valid at edge N+1. rd_valid is high for exactly one cycle per accepted pop.
- Back-to-back pops on consecutive cycles return consecutive entries, one per cycle.
- Push visibility: a word pushed at edge N can be popped by an rd_en sampled at edge N+1 or later.
- Upstream pushes can arrive every cycle. The FIFO never back-pressures upstream; loss is signalled only through overflow.

## Test plan
- Reset check: assert rst with the FIFO half full, then release. Required: count=0, empty=1, full=0, overflow=0, underflow=0, rd_valid=0, rd_data=0. A following push of 0xA5A5A5A5 then a pop returns 0xA5A5A5A5.
- Fill and drain, depth=8: push 0x1..0x8 on consecutive cycles, then pop 8 times back-to-back.
  - Required during fill: full=1 after the 8th push.
  - Required during drain: rd_data sequence 0x1..0x8 with rd_valid high 8 consecutive cycles, then empty=1 and no flags set.
- Overflow: fill with 0x10..0x17, push 0xDEAD, then drain.
  - Required: overflow=1 and count stays 8.
  - Required drain output: 0x10..0x17 only.
  - Then clr_err gives overflow=0 on the next cycle.
- Underflow and simultaneous events on empty:
  - Pop on empty: underflow=1, rd_valid=0, rd_data unchanged.
  - Push 0x55 together with rd_en on empty: count=1 and underflow set. The next pop returns 0x55.
- Full with simultaneous push and pop: with the FIFO full of 0x20..0x27, drive push 0x28 and rd_en together.
  - Required: rd_data=0x20, count stays 8, overflow=0.
  - Draining gives 0x21..0x28, which proves pointer wrap-around.
- clr_err collision: with overflow=1, assert clr_err in the same cycle as a push that is dropped because the FIFO is full. Required: overflow remains 1.

Source files
------------

// File: rtl/ext_result_fifo.sv
// ext_result_fifo: in-order capture FIFO for results from the external
// pipelined logic stage. The IDS slave drains it with registered read pops.
//
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   result_r        - result word from the upstream stage
//   result_r_in_enb - one-cycle push strobe qualifying result_r
//   rd_en           - pop request from the IDS slave
//   clr_err         - clears the sticky overflow/underflow flags
//   rd_data         - popped word, registered (holds when no pop)
//   rd_valid        - rd_data was loaded by a pop at the last edge
//   count           - occupancy, 0..depth
//   empty, full     - decoded from the registered count
//   overflow        - sticky: a push was dropped
//   underflow       - sticky: a pop hit an empty FIFO
module ext_result_fifo #(
    parameter  int bus_width = 32,
    parameter  int depth     = 8,
    localparam int cnt_width = $clog2(depth) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [bus_width-1:0] result_r,
    input  logic                 result_r_in_enb,
    input  logic                 rd_en,
    input  logic                 clr_err,
    output logic [bus_width-1:0] rd_data,
    output logic                 rd_valid,
    output logic [cnt_width-1:0] count,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int AW = $clog2(depth);
    localparam logic [cnt_width-1:0] FULL_CNT = cnt_width'(depth);

    logic [bus_width-1:0] mem_q [depth];

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic [bus_width-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;

    logic empty_w, full_w;
    logic pop_ok, push_ok;
    logic ovf_evt, udf_evt;

    assign empty_w = (cnt_q == '0);
    assign full_w  = (cnt_q == FULL_CNT);

    // A pop frees a slot in the same cycle, so a full FIFO still takes
    // a push alongside it. An empty FIFO never falls through.
    assign pop_ok  = rd_en && !empty_w;
    assign push_ok = result_r_in_enb && (!full_w || pop_ok);
    assign ovf_evt = result_r_in_enb && !push_ok;
    assign udf_evt = rd_en && empty_w;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop_ok;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem_q[rd_ptr_q];
        end

        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // A new event in the same cycle as clr_err wins.
        ovf_d = ovf_evt || (ovf_q && !clr_err);
        udf_d = udf_evt || (udf_q && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= result_r;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = cnt_q;
    assign empty     = empty_w;
    assign full      = full_w;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_ext_result_fifo.sv
// tb_ext_result_fifo: directed test-plan scenarios plus random traffic,
// checked against a queue-based reference model of the FIFO.
module tb_ext_result_fifo;

    localparam int BW  = 32;
    localparam int DEP = 8;
    localparam int CW  = $clog2(DEP) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] result_r;
    logic          result_r_in_enb;
    logic          rd_en;
    logic          clr_err;
    logic [BW-1:0] rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    ext_result_fifo #(.bus_width(BW), .depth(DEP)) dut (
        .clk            (clk),
        .rst            (rst),
        .result_r       (result_r),
        .result_r_in_enb(result_r_in_enb),
        .rd_en          (rd_en),
        .clr_err        (clr_err),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .count          (count),
        .empty          (empty),
        .full           (full),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [BW-1:0] mq[$];
    logic [BW-1:0] m_data  = '0;
    logic          m_valid = 1'b0;
    logic          m_ovf   = 1'b0;
    logic          m_udf   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare every output.
    task automatic step(input logic r, input logic p, input logic [BW-1:0] d,
                        input logic rd, input logic clr);
        bit was_empty, pop_ok, push_ok;
        rst             = r;
        result_r_in_enb = p;
        result_r        = d;
        rd_en           = rd;
        clr_err         = clr;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            was_empty = (mq.size() == 0);
            pop_ok    = rd && !was_empty;
            push_ok   = p && (mq.size() < DEP || pop_ok);
            if (pop_ok) m_data = mq.pop_front();
            if (push_ok) mq.push_back(d);
            m_valid = pop_ok;
            m_ovf   = (p && !push_ok) || (m_ovf && !clr);
            m_udf   = (rd && was_empty) || (m_udf && !clr);
        end
        #1;
        chk("count", count, mq.size());
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == DEP);
        chk("rd_valid", rd_valid, m_valid);
        chk("rd_data", rd_data, m_data);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_udf);
    endtask

    task automatic push(input logic [BW-1:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Reset with the FIFO half full.
        for (int i = 0; i < 4; i++) push(BW'(32'h100 + i));
        pop();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        push(32'hA5A5A5A5);
        pop();
        chk("rst_first_pop", rd_data, 32'hA5A5A5A5);
        idle();

        // Fill and drain.
        for (int i = 1; i <= 8; i++) push(BW'(i));
        chk("fill_full", full, 1);
        for (int i = 1; i <= 8; i++) begin
            pop();
            chk("drain_data", rd_data, i);
            chk("drain_valid", rd_valid, 1);
        end
        idle();
        chk("drain_empty", empty, 1);
        chk("drain_ovf", overflow, 0);
        chk("drain_udf", underflow, 0);

        // Overflow, then clr_err colliding with a dropped push.
        for (int i = 0; i < 8; i++) push(BW'(32'h10 + i));
        push(32'hDEAD);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 8);
        step(1'b0, 1'b1, 32'hBEEF, 1'b0, 1'b1);
        chk("ovf_clr_collide", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            pop();
            chk("ovf_drain", rd_data, 32'h10 + i);
        end
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("ovf_cleared", overflow, 0);

        // Underflow, and push+pop on empty.
        pop();
        chk("udf_set", underflow, 1);
        chk("udf_valid", rd_valid, 0);
        chk("udf_hold", rd_data, 32'h17);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h55, 1'b1, 1'b0);
        chk("pp_empty_cnt", count, 1);
        chk("pp_empty_udf", underflow, 1);
        pop();
        chk("pp_empty_pop", rd_data, 32'h55);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Push+pop when full, draining across the wrap.
        for (int i = 0; i < 8; i++) push(BW'(32'h20 + i));
        step(1'b0, 1'b1, 32'h28, 1'b1, 1'b0);
        chk("pp_full_data", rd_data, 32'h20);
        chk("pp_full_cnt", count, 8);
        chk("pp_full_ovf", overflow, 0);
        for (int i = 0; i < 8; i++) begin
            pop();
            chk("wrap_drain", rd_data, 32'h21 + i);
        end
        idle();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < 55),
                 $urandom,
                 ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
